// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between a processor port (P) and a DMA port (D).
// Define ARB_FIXED_PRIO_EN to make P win every tie instead of alternating.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              PReq,
  input  logic              PWrite,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic [DATA_W-1:0] PWData,
  output logic              PAck,
  output logic [DATA_W-1:0] PRData,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              DAck,
  output logic [DATA_W-1:0] DRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Busy,
  output logic              Owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              r_owner;
  logic              r_pAck;
  logic              r_dAck;
  logic [DATA_W-1:0] r_pRData;
  logic [DATA_W-1:0] r_dRData;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWData;
  logic              r_memWrite;

  logic              w_anyReq;
  logic              w_grantD;

  assign w_anyReq = PReq | DReq;

`ifdef ARB_FIXED_PRIO_EN
  assign w_grantD = DReq & ~PReq;
`else
  // On a tie D wins only if P held the last grant (r_owner == 0).
  assign w_grantD = DReq & (~PReq | ~r_owner);
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_owner    <= 1'b1;
      r_pAck     <= 1'b0;
      r_dAck     <= 1'b0;
      r_pRData   <= '0;
      r_dRData   <= '0;
      r_memAddr  <= '0;
      r_memWData <= '0;
      r_memWrite <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_owner    <= w_grantD;
            r_memAddr  <= w_grantD ? DAddr  : PAddr;
            r_memWData <= w_grantD ? DWData : PWData;
            r_memWrite <= w_grantD ? DWrite : PWrite;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          r_memWrite <= 1'b0;
          if (r_memWrite) begin
            r_pAck  <= ~r_owner;
            r_dAck  <= r_owner;
            r_state <= ACK;
          end else begin
            r_cnt   <= LAT;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            if (r_owner) r_dRData <= MemRData;
            else         r_pRData <= MemRData;
            r_pAck  <= ~r_owner;
            r_dAck  <= r_owner;
            r_state <= ACK;
          end
        end
        ACK: begin
          r_pAck  <= 1'b0;
          r_dAck  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign PAck     = r_pAck;
  assign DAck     = r_dAck;
  assign PRData   = r_pRData;
  assign DRData   = r_dRData;
  assign MemAddr  = r_memAddr;
  assign MemWData = r_memWData;
  assign MemWrite = r_memWrite;
  assign Owner    = r_owner;
  assign Busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level memory/fairness model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;
  localparam int RR_BOUND = 5 + 2 * RD_LAT;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic              PReq = 1'b0, PWrite = 1'b0;
  logic [ADDR_W-1:0] PAddr = '0;
  logic [DATA_W-1:0] PWData = '0;
  logic              PAck;
  logic [DATA_W-1:0] PRData;
  logic              DReq = 1'b0, DWrite = 1'b0;
  logic [ADDR_W-1:0] DAddr = '0;
  logic [DATA_W-1:0] DWData = '0;
  logic              DAck;
  logic [DATA_W-1:0] DRData;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemWrite;
  logic [DATA_W-1:0] MemRData;
  logic              Busy;
  logic              Owner;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [0:255];
  logic [DATA_W-1:0] rdPipe [0:RD_LAT-1];
  logic              tbWrEn = 1'b0;
  logic [7:0]        tbWrAddr = '0;
  logic [DATA_W-1:0] tbWrData = '0;
  logic [DATA_W-1:0] refMem [0:15];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .PReq(PReq), .PWrite(PWrite), .PAddr(PAddr), .PWData(PWData), .PAck(PAck), .PRData(PRData),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData), .DAck(DAck), .DRData(DRData),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWrite(MemWrite), .MemRData(MemRData),
    .Busy(Busy), .Owner(Owner)
  );

  always #5 Clock = ~Clock;

  // Single-port synchronous memory: data for the address present at an edge appears RD_LAT cycles later.
  always @(posedge Clock) begin
    if (tbWrEn) mem[tbWrAddr] <= tbWrData;
    else if (MemWrite) mem[MemAddr[7:0]] <= MemWData;
    rdPipe[0] <= mem[MemAddr[7:0]];
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign MemRData = rdPipe[RD_LAT-1];

  task automatic nextCycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic tbPoke(input logic [7:0] a, input logic [DATA_W-1:0] d);
    tbWrEn = 1'b1; tbWrAddr = a; tbWrData = d;
    nextCycle();
    tbWrEn = 1'b0;
  endtask

  task automatic doReset();
    PReq = 1'b0; DReq = 1'b0;
    Resetn = 1'b0;
    nextCycle();
    Resetn = 1'b1;
    nextCycle();
  endtask

  task automatic test_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    #1;
    checks++; if (PAck !== 1'b0 || DAck !== 1'b0) begin errors++; $display("[TB] FAIL reset_acks: got P=%b D=%b, expected 0 0", PAck, DAck); end
    checks++; if (PRData !== 16'h0 || DRData !== 16'h0) begin errors++; $display("[TB] FAIL reset_rdata: got P=%h D=%h, expected 0000 0000", PRData, DRData); end
    checks++; if (MemWrite !== 1'b0 || MemAddr !== 16'h0 || MemWData !== 16'h0) begin errors++; $display("[TB] FAIL reset_mem: got we=%b a=%h d=%h, expected 0 0000 0000", MemWrite, MemAddr, MemWData); end
    checks++; if (Busy !== 1'b0 || Owner !== 1'b1) begin errors++; $display("[TB] FAIL reset_state: got busy=%b owner=%b, expected 0 1", Busy, Owner); end
    nextCycle();
    Resetn = 1'b1;
    nextCycle();
    checks++; if (Busy !== 1'b0 || Owner !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got busy=%b owner=%b, expected 0 1", Busy, Owner); end
  endtask

  task automatic test_p_write();
    int dAckSeen = 0;
    PReq = 1'b1; PWrite = 1'b1; PAddr = 16'h0010; PWData = 16'hABCD;
    nextCycle();
    if (DAck === 1'b1) dAckSeen++;
    checks++; if (MemWrite !== 1'b1 || MemAddr !== 16'h0010 || MemWData !== 16'hABCD) begin errors++; $display("[TB] FAIL pwr_access: got we=%b a=%h d=%h, expected 1 0010 abcd", MemWrite, MemAddr, MemWData); end
    checks++; if (PAck !== 1'b0 || Busy !== 1'b1 || Owner !== 1'b0) begin errors++; $display("[TB] FAIL pwr_c1_ctrl: got ack=%b busy=%b owner=%b, expected 0 1 0", PAck, Busy, Owner); end
    nextCycle();
    if (DAck === 1'b1) dAckSeen++;
    checks++; if (PAck !== 1'b1 || MemWrite !== 1'b0) begin errors++; $display("[TB] FAIL pwr_ack: got ack=%b we=%b, expected 1 0", PAck, MemWrite); end
    PReq = 1'b0;
    nextCycle();
    if (DAck === 1'b1) dAckSeen++;
    checks++; if (PAck !== 1'b0 || Busy !== 1'b0) begin errors++; $display("[TB] FAIL pwr_done: got ack=%b busy=%b, expected 0 0", PAck, Busy); end
    checks++; if (dAckSeen != 0) begin errors++; $display("[TB] FAIL pwr_dack: got %0d DAck cycles, expected 0", dAckSeen); end
  endtask

  task automatic test_d_read();
    int weSeen = 0;
    tbPoke(8'h20, 16'h1234);
    DReq = 1'b1; DWrite = 1'b0; DAddr = 16'h0020; DWData = 16'($urandom);
    nextCycle();
    if (MemWrite === 1'b1) weSeen++;
    checks++; if (MemAddr !== 16'h0020 || Busy !== 1'b1 || DAck !== 1'b0) begin errors++; $display("[TB] FAIL drd_access: got a=%h busy=%b ack=%b, expected 0020 1 0", MemAddr, Busy, DAck); end
    nextCycle();
    if (MemWrite === 1'b1) weSeen++;
    checks++; if (DAck !== 1'b0 || Busy !== 1'b1) begin errors++; $display("[TB] FAIL drd_wait: got ack=%b busy=%b, expected 0 1", DAck, Busy); end
    nextCycle();
    if (MemWrite === 1'b1) weSeen++;
    checks++; if (DAck !== 1'b1 || DRData !== 16'h1234 || PAck !== 1'b0) begin errors++; $display("[TB] FAIL drd_ack: got ack=%b data=%h pack=%b, expected 1 1234 0", DAck, DRData, PAck); end
    DReq = 1'b0;
    nextCycle();
    checks++; if (DAck !== 1'b0 || DRData !== 16'h1234 || Owner !== 1'b1) begin errors++; $display("[TB] FAIL drd_hold: got ack=%b data=%h owner=%b, expected 0 1234 1", DAck, DRData, Owner); end
    checks++; if (weSeen != 0) begin errors++; $display("[TB] FAIL drd_nowrite: got %0d write cycles, expected 0", weSeen); end
  endtask

  task automatic test_tie();
    doReset();
    PReq = 1'b1; PWrite = 1'b1; PAddr = 16'h0001; PWData = 16'h1111;
    DReq = 1'b1; DWrite = 1'b1; DAddr = 16'h0002; DWData = 16'h2222;
    nextCycle();
    checks++; if (Owner !== 1'b0 || MemAddr !== 16'h0001 || MemWrite !== 1'b1) begin errors++; $display("[TB] FAIL tie_first: got owner=%b a=%h we=%b, expected 0 0001 1", Owner, MemAddr, MemWrite); end
    nextCycle();
    checks++; if (PAck !== 1'b1 || DAck !== 1'b0) begin errors++; $display("[TB] FAIL tie_pack: got P=%b D=%b, expected 1 0", PAck, DAck); end
    PReq = 1'b0;
    nextCycle();
    nextCycle();
    checks++; if (Owner !== 1'b1 || MemAddr !== 16'h0002 || MemWData !== 16'h2222 || MemWrite !== 1'b1) begin errors++; $display("[TB] FAIL tie_second: got owner=%b a=%h d=%h we=%b, expected 1 0002 2222 1", Owner, MemAddr, MemWData, MemWrite); end
    nextCycle();
    checks++; if (DAck !== 1'b1 || PAck !== 1'b0) begin errors++; $display("[TB] FAIL tie_dack: got P=%b D=%b, expected 0 1", PAck, DAck); end
    DReq = 1'b0;
    nextCycle();
  endtask

  task automatic test_alternation();
    int n;
    logic expD;
    PReq = 1'b1; PWrite = 1'b1; PAddr = 16'h0030; PWData = 16'h3030;
    DReq = 1'b1; DWrite = 1'b1; DAddr = 16'h0040; DWData = 16'h4040;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin nextCycle(); n++; end while (MemWrite !== 1'b1 && n < 12);
`ifdef ARB_FIXED_PRIO_EN
      expD = 1'b0;
`else
      expD = (g % 2) == 1;
`endif
      checks++;
      if (MemWrite !== 1'b1) begin errors++; $display("[TB] FAIL alt_grant%0d: got no grant in %0d cycles, expected one", g, n); end
      else if ((MemAddr == 16'h0040) !== expD || Owner !== expD) begin errors++; $display("[TB] FAIL alt_grant%0d: got addr=%h owner=%b, expected owner %b", g, MemAddr, Owner, expD); end
    end
    n = 0;
    do begin nextCycle(); n++; end while (PAck !== 1'b1 && DAck !== 1'b1 && n < 12);
    PReq = 1'b0;
    n = 0;
    do begin nextCycle(); n++; end while (MemWrite !== 1'b1 && n < 12);
    checks++; if (MemWrite !== 1'b1 || MemAddr !== 16'h0040 || Owner !== 1'b1) begin errors++; $display("[TB] FAIL alt_dlast: got we=%b addr=%h owner=%b, expected 1 0040 1", MemWrite, MemAddr, Owner); end
    n = 0;
    do begin nextCycle(); n++; end while (DAck !== 1'b1 && n < 12);
    checks++; if (DAck !== 1'b1) begin errors++; $display("[TB] FAIL alt_dack: got %b after %0d cycles, expected 1", DAck, n); end
    DReq = 1'b0;
    nextCycle();
  endtask

  task automatic test_reset_mid();
    int ackSeen = 0;
    DReq = 1'b1; DWrite = 1'b0; DAddr = 16'h0020;
    nextCycle();
    nextCycle();
    Resetn = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0 || DAck !== 1'b0 || DRData !== 16'h0 || MemWrite !== 1'b0 || Owner !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset: got busy=%b ack=%b data=%h we=%b owner=%b, expected 0 0 0000 0 1", Busy, DAck, DRData, MemWrite, Owner); end
    DReq = 1'b0;
    nextCycle();
    Resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      if (DAck === 1'b1 || MemWrite === 1'b1 || Busy === 1'b1) ackSeen++;
    end
    checks++; if (ackSeen != 0) begin errors++; $display("[TB] FAIL mid_quiet: got %0d active cycles after reset, expected 0", ackSeen); end
    PReq = 1'b1; PWrite = 1'b0; PAddr = 16'h0010;
    nextCycle();
    nextCycle();
    nextCycle();
    checks++; if (PAck !== 1'b1 || PRData !== 16'hABCD || Owner !== 1'b0) begin errors++; $display("[TB] FAIL mid_pread: got ack=%b data=%h owner=%b, expected 1 abcd 0", PAck, PRData, Owner); end
    PReq = 1'b0;
    nextCycle();
  endtask

  task automatic runRequester(input bit isD, input int nTrans);
    int gap, waited, limit;
    bit wr, got;
    logic [3:0] a;
    logic [DATA_W-1:0] d;
`ifdef ARB_FIXED_PRIO_EN
    limit = isD ? 600 : RR_BOUND;
`else
    limit = RR_BOUND;
`endif
    for (int t = 0; t < nTrans; t++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge Clock);
      wr = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      d = 16'($urandom);
      if (isD) begin DReq = 1'b1; DWrite = wr; DAddr = {12'h0, a}; DWData = d; end
      else     begin PReq = 1'b1; PWrite = wr; PAddr = {12'h0, a}; PWData = d; end
      waited = 0; got = 1'b0;
      while (!got && waited < limit) begin
        @(negedge Clock);
        waited++;
        if ((isD ? DAck : PAck) === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++; $display("[TB] FAIL rnd_timeout_%s: got no ack in %0d cycles, expected ack", isD ? "D" : "P", waited);
      end else begin
        if (Owner !== isD || (isD ? PAck : DAck) !== 1'b0) begin
          errors++; $display("[TB] FAIL rnd_owner_%s: got owner=%b otherAck=%b, expected %b 0", isD ? "D" : "P", Owner, isD ? PAck : DAck, isD);
        end
        checks++;
        if (waited < (wr ? 2 : 2 + RD_LAT)) begin
          errors++; $display("[TB] FAIL rnd_latency_%s: got %0d cycles, expected at least %0d", isD ? "D" : "P", waited, wr ? 2 : 2 + RD_LAT);
        end
        if (wr) refMem[a] = d;
        else begin
          checks++;
          if ((isD ? DRData : PRData) !== refMem[a]) begin
            errors++; $display("[TB] FAIL rnd_rdata_%s: got %h, expected %h (addr %h)", isD ? "D" : "P", isD ? DRData : PRData, refMem[a], a);
          end
        end
      end
      if (isD) DReq = 1'b0; else PReq = 1'b0;
      @(negedge Clock);
      checks++;
      if ((isD ? DAck : PAck) !== 1'b0) begin errors++; $display("[TB] FAIL rnd_pulse_%s: got ack=%b, expected 0", isD ? "D" : "P", isD ? DAck : PAck); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      refMem[i] = 16'($urandom);
      tbPoke(8'(i), refMem[i]);
    end
    fork
      runRequester(1'b0, 20);
      runRequester(1'b1, 20);
    join
    nextCycle();
  endtask

  initial begin
    test_reset();
    test_p_write();
    test_d_read();
    test_tie();
    test_alternation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
